// File: rtl/inst_encoder.sv
// RV32I instruction encoder and program writer.
// Packs decoded instruction fields into 32-bit words and streams them into
// instruction memory at auto-incrementing byte addresses. Requests whose
// format or immediate is illegal are dropped and recorded in sticky error
// state. Data path: input check/encode -> stage1 register -> FIFO -> imem port.
module inst_encoder #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       wr_count,
  output logic [7:0]        rej_count
);

  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_BAD6 = 3'd6,
    FMT_BAD7 = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_FMT   = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_ALIGN = 2'd3
  } err_e;

  // Request-side encode and legality check
  fmt_e        fmt;
  logic        shift_imm;
  logic        fits_12;
  logic        fits_13;
  logic        fits_21;
  logic [31:0] enc_word;
  err_e        enc_err;

  // Stage1
  logic        s1_valid;
  logic [31:0] s1_word;

  // FIFO
  logic [31:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // Handshake / movement strobes
  logic accept;
  logic pop;
  logic fifo_full;
  logic push;
  err_e err_q;

  assign fmt       = fmt_e'(in_fmt);
  // SLLI/SRLI/SRAI: OP-IMM with funct3 001 or 101
  assign shift_imm = (in_opcode == 7'b0010011) && (in_funct3[1:0] == 2'b01);
  // An immediate fits N signed bits when all bits from N-1 upward agree
  assign fits_12   = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fits_13   = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign fits_21   = (&in_imm[31:20]) || !(|in_imm[31:20]);

  // Pack the instruction word and classify the first failing check
  always_comb begin
    enc_word = '0;
    enc_err  = ERR_NONE;
    case (fmt)
      FMT_R: begin
        enc_word = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I: begin
        if (shift_imm) begin
          enc_word = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          if (in_imm[31:5] != '0) enc_err = ERR_RANGE;
        end else begin
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          if (!fits_12) enc_err = ERR_RANGE;
        end
      end
      FMT_S: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (!fits_12) enc_err = ERR_RANGE;
      end
      FMT_B: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        if (!fits_13)      enc_err = ERR_RANGE;
        else if (in_imm[0]) enc_err = ERR_ALIGN;
      end
      FMT_U: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
        if (in_imm[11:0] != '0) enc_err = ERR_ALIGN;
      end
      FMT_J: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (!fits_21)      enc_err = ERR_RANGE;
        else if (in_imm[0]) enc_err = ERR_ALIGN;
      end
      default: begin
        enc_err = ERR_FMT;
      end
    endcase
  end

  assign fifo_full = (count == FULL_CNT);
  assign mem_we    = (count != '0);
  assign pop       = mem_we && mem_ready && !start;
  // Push into a full FIFO is allowed when the head leaves in the same cycle
  assign push      = s1_valid && !start && (!fifo_full || (mem_we && mem_ready));
  // rst_n gates ready so nothing is offered while reset is held
  assign in_ready  = rst_n && !start && (!s1_valid || push);
  assign accept    = in_valid && in_ready;
  assign mem_wdata = fifo_mem[rd_ptr];
  assign busy      = s1_valid || mem_we;
  assign err_code  = err_q;

  // Stage1: capture accepted legal words; rejected ones leave it empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else if (start) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= (enc_err == ERR_NONE);
      s1_word  <= enc_word;
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else if (push) begin
      fifo_mem[wr_ptr] <= s1_word;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write address and completed-write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      wr_count <= '0;
    end else if (start) begin
      mem_addr <= base_addr;
      wr_count <= '0;
    end else if (pop) begin
      mem_addr <= mem_addr + ADDR_W'(4);
      wr_count <= wr_count + 16'd1;
    end
  end

  // Sticky error, first-cause code and saturating reject counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_q     <= ERR_NONE;
      rej_count <= '0;
    end else if (start) begin
      err       <= 1'b0;
      err_q     <= ERR_NONE;
      rej_count <= '0;
    end else if (accept && (enc_err != ERR_NONE)) begin
      err <= 1'b1;
      if (!err) err_q <= enc_err;
      if (rej_count != 8'hFF) rej_count <= rej_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors from the ISA
// encoding rules plus randomized traffic against a behavioural model.
module tb_inst_encoder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_fmt = '0;
  logic [6:0]        in_opcode = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [2:0]        in_funct3 = '0;
  logic              in_alt = 1'b0;
  logic [31:0]       in_imm = '0;
  logic              mem_we;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              err;
  logic [1:0]        err_code;
  logic [15:0]       wr_count;
  logic [7:0]        rej_count;

  inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .err(err), .err_code(err_code),
    .wr_count(wr_count), .rej_count(rej_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 0: mem_ready high, 1: low, 2: random
  int ready_mode = 0;
  always begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = 1'b0;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  typedef struct {
    int          fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
  } req_t;

  // Model state
  logic [31:0]         exp_q[$];
  logic [ADDR_W+31:0]  got_q[$];
  logic [ADDR_W-1:0]   m_addr = '0;
  bit                  m_err = 0;
  int                  m_code = 0;
  int                  m_wr = 0;
  int                  m_rej = 0;

  // Record each write that will complete on the coming rising edge
  always @(negedge clk) begin
    if (rst_n && !start && mem_we && mem_ready) got_q.push_back({mem_addr, mem_wdata});
  end

  function automatic logic [31:0] ref_encode(input req_t r);
    logic [31:0] o, d, a, b, f, s, w, im;
    o = 32'(r.op); d = 32'(r.rd); a = 32'(r.rs1); b = 32'(r.rs2);
    f = 32'(r.f3); s = 32'(r.alt); im = r.imm;
    case (r.fmt)
      0: w = (s << 30) | (b << 20) | (a << 15) | (f << 12) | (d << 7) | o;
      1: if (r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5))
           w = (s << 30) | ((im & 32'h1F) << 20) | (a << 15) | (f << 12) | (d << 7) | o;
         else
           w = ((im & 32'hFFF) << 20) | (a << 15) | (f << 12) | (d << 7) | o;
      2: w = (((im >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (f << 12)
           | ((im & 32'h1F) << 7) | o;
      3: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (b << 20)
           | (a << 15) | (f << 12) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | o;
      4: w = (im & 32'hFFFFF000) | (d << 7) | o;
      5: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
           | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | (d << 7) | o;
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic int ref_check(input req_t r);
    int v;
    v = $signed(r.imm);
    if (r.fmt >= 6) return 1;
    case (r.fmt)
      1: if (r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5)) return (r.imm > 32'd31) ? 2 : 0;
         else return (v < -2048 || v > 2047) ? 2 : 0;
      2: return (v < -2048 || v > 2047) ? 2 : 0;
      3: begin
        if (v < -4096 || v > 4095) return 2;
        return (r.imm % 2 != 0) ? 3 : 0;
      end
      4: return (r.imm % 4096 != 0) ? 3 : 0;
      5: begin
        if (v < -1048576 || v > 1048575) return 2;
        return (r.imm % 2 != 0) ? 3 : 0;
      end
      default: return 0;
    endcase
  endfunction

  function automatic req_t mk(input int fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic alt, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.f3 = f3; r.alt = alt; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_r();
    return mk(0, 7'h33, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), $urandom);
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r = mk($urandom_range(0, 7), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 1'($urandom), $urandom);
    if (r.fmt == 1 && $urandom_range(0, 1) == 1) r.op = 7'h13;
    case ($urandom_range(0, 3))
      0: r.imm = $urandom;
      1: r.imm = 32'($urandom_range(0, 80)) - 32'd40;
      2: r.imm = ($urandom & 32'h1FFE) - 32'd4096;
      default: r.imm = $urandom & 32'hFFFFF000;
    endcase
    return r;
  endfunction

  task automatic model_accept(input req_t r);
    int code;
    code = ref_check(r);
    if (code != 0) begin
      if (m_rej < 255) m_rej++;
      if (!m_err) begin m_err = 1; m_code = code; end
    end else begin
      exp_q.push_back(ref_encode(r));
    end
  endtask

  // Drive one request from the posedge+1 phase; returns at posedge+1 after acceptance
  task automatic send(input req_t r);
    bit ok, acc;
    ok = 0;
    in_fmt = 3'(r.fmt); in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_alt = r.alt; in_imm = r.imm;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin ok = 1; model_accept(r); end
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL accept_timeout got=no_accept exp=accept"); end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_timeout got=busy exp=idle"); end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    base_addr = base;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_addr = base; m_err = 0; m_code = 0; m_wr = 0; m_rej = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    logic [ADDR_W+63:0] v;
    repeat (3) @(negedge clk);
    v = {in_ready, mem_we, mem_addr, mem_wdata, busy, err, err_code, wr_count, rej_count};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", v); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_formats();
    logic [31:0] words [5];
    words = '{32'h002081B3, 32'h402081B3, 32'hFE208EE3, 32'h123452B7, 32'h001000EF};
    ready_mode = 0;
    do_start(12'h100);
    checks++;
    if (mem_addr !== 12'h100) begin errors++; $display("FAIL start_addr got=%h exp=100", mem_addr); end
    send(mk(0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0));
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL latency_early got=%b exp=0", mem_we); end
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h100, 32'h002081B3}) begin
      errors++; $display("FAIL latency_write got=%b/%h/%h exp=1/100/002081b3", mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    send(mk(0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0));
    wait_idle();
    checks++;
    if (wr_count !== 16'd2) begin errors++; $display("FAIL wr_count_two got=%0d exp=2", wr_count); end
    send(mk(3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC));
    send(mk(4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000));
    send(mk(5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000800));
    wait_idle();
    checks++;
    if (got_q.size() != 5) begin errors++; $display("FAIL formats_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {12'h100 + 12'(4 * i), words[i]}) begin
        errors++; $display("FAIL format_word%0d got=%h exp=%h", i, got_q[i], {12'h100 + 12'(4 * i), words[i]});
      end
    end
    got_q.delete(); exp_q.delete();
    m_addr = m_addr + 12'd20; m_wr += 5;
  endtask

  task automatic test_errors();
    logic [31:0] words [5];
    words = '{32'h00208363, 32'h01F09093, 32'h41F0D093, 32'h80000093, 32'hFE20AFA3};
    send(mk(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048));
    wait_idle();
    checks++;
    if ({got_q.size() == 0, err, err_code, rej_count} !== {1'b1, 1'b1, 2'd2, 8'd1}) begin
      errors++; $display("FAIL reject_range got=%0d/%b/%0d/%0d exp=0/1/2/1", got_q.size(), err, err_code, rej_count);
    end
    send(mk(3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd6));
    send(mk(5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3));
    send(mk(7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0));
    send(mk(4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345001));
    send(mk(1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 1'b0, 32'd32));
    send(mk(1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 1'b0, 32'd31));
    send(mk(1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 1'b1, 32'd31));
    send(mk(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFF800));
    send(mk(2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'hFFFFFFFF));
    wait_idle();
    checks++;
    if ({err, err_code, rej_count, wr_count} !== {1'b1, 2'd2, 8'd5, 16'd10}) begin
      errors++; $display("FAIL reject_mix got=%b/%0d/%0d/%0d exp=1/2/5/10", err, err_code, rej_count, wr_count);
    end
    checks++;
    if (got_q.size() != 5) begin errors++; $display("FAIL legal_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {12'h114 + 12'(4 * i), words[i]}) begin
        errors++; $display("FAIL legal_word%0d got=%h exp=%h", i, got_q[i], {12'h114 + 12'(4 * i), words[i]});
      end
    end
  endtask

  task automatic test_backpressure();
    int accepts;
    bit acc;
    req_t r;
    logic [31:0] w1;
    logic [ADDR_W+31:0] g;
    do_start(12'h080);
    ready_mode = 1;
    accepts = 0;
    r = rand_r();
    in_fmt = 3'(r.fmt); in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_alt = r.alt; in_imm = r.imm;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        accepts++;
        model_accept(r);
        r = rand_r();
        in_fmt = 3'(r.fmt); in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
        in_funct3 = r.f3; in_alt = r.alt; in_imm = r.imm;
      end
    end
    @(negedge clk);
    checks++;
    if ({accepts, in_ready} !== {32'd5, 1'b0}) begin
      errors++; $display("FAIL stall_accepts got=%0d/%b exp=5/0", accepts, in_ready);
    end
    w1 = mem_wdata;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_we, mem_wdata, mem_addr} !== {1'b1, w1, 12'h080} || mem_wdata !== exp_q[0]) begin
      errors++; $display("FAIL stall_stable got=%b/%h/%h exp=1/%h/080", mem_we, mem_wdata, mem_addr, exp_q[0]);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ready_mode = 0;
    wait_idle();
    while (exp_q.size() > 0) begin
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL bp_write got=none exp=%h", exp_q[0]); void'(exp_q.pop_front());
      end else begin
        g = got_q.pop_front();
        if (g !== {m_addr, exp_q[0]}) begin
          errors++; $display("FAIL bp_write got=%h exp=%h", g, {m_addr, exp_q[0]});
        end
        void'(exp_q.pop_front());
        m_addr = m_addr + ADDR_W'(4); m_wr++;
      end
    end
    checks++;
    if (wr_count !== 16'(m_wr)) begin errors++; $display("FAIL bp_wr_count got=%0d exp=%0d", wr_count, m_wr); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W+31:0] g;
    do_start(12'hFFC);
    send(rand_r());
    send(rand_r());
    wait_idle();
    while (exp_q.size() > 0) begin
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL wrap_write got=none exp=%h", exp_q[0]); void'(exp_q.pop_front());
      end else begin
        g = got_q.pop_front();
        if (g !== {m_addr, exp_q[0]}) begin
          errors++; $display("FAIL wrap_write got=%h exp=%h", g, {m_addr, exp_q[0]});
        end
        void'(exp_q.pop_front());
        m_addr = m_addr + ADDR_W'(4); m_wr++;
      end
    end
    checks++;
    if (mem_addr !== 12'h004) begin errors++; $display("FAIL wrap_addr got=%h exp=004", mem_addr); end
  endtask

  task automatic test_start_flush();
    logic [ADDR_W+63:0] v;
    ready_mode = 1;
    do_start(12'h040);
    send(mk(3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd5));
    send(rand_r());
    send(rand_r());
    send(rand_r());
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({busy, mem_we, err_code, rej_count} !== {1'b1, 1'b1, 2'd3, 8'd1}) begin
      errors++; $display("FAIL pre_flush got=%b/%b/%0d/%0d exp=1/1/3/1", busy, mem_we, err_code, rej_count);
    end
    @(posedge clk);
    #1;
    in_fmt = 3'd0; in_opcode = 7'h33; in_valid = 1'b1;
    base_addr = 12'h200;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_during_start got=%b exp=0", in_ready); end
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    v = {mem_we, busy, err, err_code, wr_count, rej_count, mem_addr, 32'd0, 1'b0};
    checks++;
    if (v !== {2'b00, 1'b0, 2'd0, 16'd0, 8'd0, 12'h200, 32'd0, 1'b0}) begin
      errors++; $display("FAIL flush_state got=%b/%b/%b/%0d/%0d/%0d/%h exp=0/0/0/0/0/0/200",
                         mem_we, busy, err, err_code, wr_count, rej_count, mem_addr);
    end
    @(posedge clk);
    #1;
    ready_mode = 0;
    m_addr = 12'h200; m_err = 0; m_code = 0; m_wr = 0; m_rej = 0;
    exp_q.delete(); got_q.delete();
    send(mk(0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0));
    wait_idle();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {12'h200, 32'h002081B3}) begin
      errors++; $display("FAIL post_flush_write got=%0d exp=1 write at 200", got_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic [ADDR_W+63:0] v;
    ready_mode = 1;
    do_start(12'h300);
    send(rand_r());
    send(rand_r());
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL pre_reset_we got=%b exp=1", mem_we); end
    #2;
    rst_n = 1'b0;
    #1;
    v = {in_ready, mem_we, mem_addr, mem_wdata, busy, err, err_code, wr_count, rej_count};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL async_reset got=%h exp=0", v); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    checks++;
    if ({mem_we, busy, wr_count} !== '0) begin
      errors++; $display("FAIL after_reset got=%b/%b/%0d exp=0/0/0", mem_we, busy, wr_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    do_start(12'h000);
    for (int i = 0; i < 260; i++) send(mk(6, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0));
    wait_idle();
    checks++;
    if ({rej_count, err, err_code, wr_count} !== {8'd255, 1'b1, 2'd1, 16'd0}) begin
      errors++; $display("FAIL rej_saturate got=%0d/%b/%0d/%0d exp=255/1/1/0", rej_count, err, err_code, wr_count);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W+31:0] g;
    do_start(ADDR_W'($urandom) & 12'hFFC);
    ready_mode = 2;
    for (int i = 0; i < 120; i++) begin
      send(rand_req());
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    ready_mode = 0;
    wait_idle();
    while (exp_q.size() > 0) begin
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL rand_write got=none exp=%h", exp_q[0]); void'(exp_q.pop_front());
      end else begin
        g = got_q.pop_front();
        if (g !== {m_addr, exp_q[0]}) begin
          errors++; $display("FAIL rand_write got=%h exp=%h", g, {m_addr, exp_q[0]});
        end
        void'(exp_q.pop_front());
        m_addr = m_addr + ADDR_W'(4); m_wr++;
      end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL rand_extra got=%0d exp=0", got_q.size()); end
    checks++;
    if ({wr_count, rej_count, err, err_code} !== {16'(m_wr), 8'(m_rej), m_err, 2'(m_code)}) begin
      errors++; $display("FAIL rand_status got=%0d/%0d/%b/%0d exp=%0d/%0d/%b/%0d",
                         wr_count, rej_count, err, err_code, m_wr, m_rej, m_err, m_code);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_errors();
    test_backpressure();
    test_wrap();
    test_start_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
